dc_fifo_stream_reader: RTL and testbench
========================================

# dc_fifo_stream_reader

Read-side consumer for the dual-clock FIFO: drains the FIFO's standard-mode read port (read latency 1, `rd_valid` strobe) in the read clock domain. It presents the data as an AXI-Stream master with frame boundaries. Each FIFO word carries a payload plus an end-of-frame bit. The block enforces a maximum frame length, reports frame length per frame, and flags protocol errors. It sits between the RX-path CDC FIFO and the ARP/Ethernet frame parser.

## Interface
- Clock/reset: one clock; reset is asynchronous and active-low (ports `rd_clk`, `rd_rst_n`).
- `DATA_WIDTH`, 32: AXI-Stream payload width; FIFO word width is `DATA_WIDTH+1`.
- `MAX_BEATS`, 384: maximum beats per frame, must be ≥ 2.
- `LEN_WIDTH`, `$clog2(MAX_BEATS+1)`: width of `frame_len`.

Ports:
- `rd_clk`  in  1  read-domain clock
- `rd_rst_n`  in  1  async active-low reset
- `fifo_rd_en`  out  1  read request to FIFO
- `fifo_rd_data`  in  DATA_WIDTH+1  bit [DATA_WIDTH] = last, [DATA_WIDTH-1:0] = payload
- `fifo_rd_empty`  in  1  FIFO empty
- `fifo_rd_valid`  in  1  `fifo_rd_data` valid this cycle
- `fifo_rd_rst_busy`  in  1  FIFO read side in reset
- `m_axis_tdata`  out  DATA_WIDTH  payload
- `m_axis_tvalid`  out  1  beat valid
- `m_axis_tready`  in  1  sink ready
- `m_axis_tlast`  out  1  last beat of frame
- `frame_len`  out  LEN_WIDTH  beats in completed frame
- `frame_len_valid`  out  1  one-cycle strobe
- `err_oversize`  out  1  sticky: frame truncated
- `err_unexpected`  out  1  sticky: `fifo_rd_valid` with no outstanding read
- `err_clr`  in  1  clears both sticky errors

## Operation
- 2-entry output buffer; `inflight` counter (0..2) tracks issued-but-unreturned reads.
- `fifo_rd_en` = `!fifo_rd_empty && !fifo_rd_rst_busy && (count + inflight - pop) < 2`.
  - `pop` = `m_axis_tvalid && m_axis_tready`.
  - The request is combinational from registered state and the inputs.
- `fifo_rd_valid` with `inflight==0`: word dropped, `err_unexpected` set.
- Input state machine (evaluated on each accepted `fifo_rd_valid`):
  - `ST_IDLE`:
    - word written to buffer; `in_cnt` = 1.
    - last=1: stay in `ST_IDLE`, `in_cnt` cleared.
    - last=0: go to `ST_FRAME`.
  - `ST_FRAME`:
    - word written to buffer; `in_cnt`++.
    - last=1: go to `ST_IDLE`, `in_cnt` cleared.
    - `in_cnt` reaches `MAX_BEATS` with last=0: written with tlast forced to 1, `err_oversize` set, go to `ST_DISCARD`.
  - `ST_DISCARD`: words dropped (not buffered) until a word with last=1, which is also dropped; then go to `ST_IDLE`.
- Output counter `out_cnt` increments on each `pop`.
  - On a `pop` with `m_axis_tlast`: `frame_len` = `out_cnt+1`, `frame_len_valid` pulses, `out_cnt` cleared.
  - `frame_len` holds its value until the next frame completes.
- Sticky errors: a set in the same cycle as `err_clr` wins.
- `fifo_rd_rst_busy` gates only `fifo_rd_en`. In-flight words still land. State and counters are unaffected.
- Async reset at any point: state `ST_IDLE`, buffer empty, all counters 0.

## Timing
- Reset values: all outputs 0.
- Latency: `fifo_rd_en` high in cycle N → `fifo_rd_valid` in N+1 → `m_axis_tvalid` in N+2 (registered buffer output).
- Throughput: 1 beat/cycle sustained with `m_axis_tready` held high and the FIFO non-empty.
- AXI-S rules:
  - `tvalid` is never withdrawn without `tready`.
  - `tdata`/`tlast` are stable while `tvalid && !tready`.
- Backpressure: at most 2 words are ever held (buffered + in-flight), so no overflow is possible.
- Simultaneous write and `pop` on a full buffer is legal. Order is preserved.
- `frame_len_valid` fires in the same cycle as the `tlast` handshake.

## Structure
- `dc_fifo_pkg`:
  - `rd_state_e` (`ST_IDLE`, `ST_FRAME`, `ST_DISCARD`).
  - `fifo_word_t` packed struct {last, payload}, parameterised by a package-level default width.
  - Constant `RD_BUF_DEPTH = 2`.
- Sub-module `dc_fifo_rd_buf`: 2-entry valid/ready buffer with push, `count` and AXI-S output. It holds no frame logic. The top holds the credit logic, FSM, counters and errors.

## Test plan
- 3-word frame (A,B,C, last on C), `tready`=1 → `fifo_rd_en` N..N+2, `tvalid` from N+2, `tlast` on C, `frame_len`=3 strobe.
- 8-word frame, `tready` low cycles 3–7 → `fifo_rd_en` drops once 2 are outstanding/buffered; all 8 words are delivered in order with no duplicates.
- `MAX_BEATS`=4, 6-word frame, then a 2-word frame:
  - First frame: 4 beats out, `tlast` on beat 4, `frame_len`=4, `err_oversize`=1.
  - Second frame: intact, `frame_len`=2.
- `fifo_rd_valid` pulse with no read issued → `err_unexpected`=1 and no AXI beat. `err_clr` → 0 next cycle.
- `fifo_rd_rst_busy`=1 with `fifo_rd_empty`=0 → `fifo_rd_en` stays 0. Release → reads resume next cycle.
- `rd_rst_n` low mid-frame with `tvalid`=1 → all outputs 0 immediately. After release, the next frame is delivered with `frame_len` counting from 1.

Source files
------------

// File: rtl/dc_fifo_pkg.sv
// Shared types and constants for the dual-clock FIFO read-side stream adapter.
package dc_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int RD_BUF_DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_DISCARD
  } rd_state_e;

  typedef struct packed {
    logic                      last;
    logic [DEF_DATA_WIDTH-1:0] payload;
  } fifo_word_t;

endpackage

// File: rtl/dc_fifo_rd_buf.sv
// Two-entry output skid buffer with an AXI-Stream style head; no frame awareness.
// Handshake: a beat transfers when m_tvalid_o && m_tready_i; valid never drops without ready.
module dc_fifo_rd_buf
  import dc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH:0]   push_data_i,
  input  logic                  m_tready_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tlast_o,
  output logic                  m_tvalid_o,
  output logic                  pop_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH:0] slot0_q, slot0_d;
  logic [DATA_WIDTH:0] slot1_q, slot1_d;
  logic [1:0]          count_q, count_d;
  logic                pop;

  assign pop = (count_q != 2'd0) && m_tready_i;

  // slot0 is always the head; slot1 only ever holds the younger word.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push_i, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          slot0_d = push_data_i;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          slot1_d = push_data_i;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = push_data_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign m_tvalid_o = (count_q != 2'd0);
  assign m_tlast_o  = slot0_q[DATA_WIDTH];
  assign m_tdata_o  = slot0_q[DATA_WIDTH-1:0];
  assign pop_o      = pop;
  assign count_o    = 2'(RD_BUF_DEPTH) - (2'(RD_BUF_DEPTH) - count_q);

endmodule

// File: rtl/dc_fifo_stream_reader.sv
// Drains a latency-1 FIFO read port into an AXI-Stream master, enforcing a maximum
// frame length and reporting per-frame beat counts and sticky protocol errors.
module dc_fifo_stream_reader
  import dc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 384,
  parameter int LEN_WIDTH  = $clog2(MAX_BEATS + 1)
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH:0]   fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  fifo_rd_valid,
  input  logic                  fifo_rd_rst_busy,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  frame_len_valid,
  output logic                  err_oversize,
  output logic                  err_unexpected,
  input  logic                  err_clr
);

  rd_state_e            state_q, state_d;
  logic [1:0]           inflight_q, inflight_d;
  logic [LEN_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [LEN_WIDTH-1:0] frame_len_q, frame_len_d;
  logic                 err_ovs_q, err_ovs_d;
  logic                 err_unexp_q, err_unexp_d;
  logic                 en_q;

  logic       accept, word_last, push, push_last, ovs_set, pop, frame_done;
  logic [1:0] buf_count;
  logic [2:0] occupancy;

  assign accept    = fifo_rd_valid && (inflight_q != 2'd0);
  assign word_last = fifo_rd_data[DATA_WIDTH];

  // Credit: buffered + in-flight words after this cycle's pop must stay below two.
  // en_q keeps the request low while reset is asserted and for one cycle after.
  assign occupancy  = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
  assign fifo_rd_en = en_q && !fifo_rd_empty && !fifo_rd_rst_busy && (occupancy < 3'd2);
  assign inflight_d = inflight_q + 2'(fifo_rd_en) - 2'(accept);

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    push      = 1'b0;
    push_last = word_last;
    ovs_set   = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          push = 1'b1;
          if (word_last) begin
            in_cnt_d = '0;
          end else begin
            in_cnt_d = LEN_WIDTH'(1);
            state_d  = ST_FRAME;
          end
        end
        ST_FRAME: begin
          push = 1'b1;
          if (word_last) begin
            in_cnt_d = '0;
            state_d  = ST_IDLE;
          end else if (in_cnt_q + LEN_WIDTH'(1) == LEN_WIDTH'(MAX_BEATS)) begin
            push_last = 1'b1;
            ovs_set   = 1'b1;
            in_cnt_d  = '0;
            state_d   = ST_DISCARD;
          end else begin
            in_cnt_d = in_cnt_q + LEN_WIDTH'(1);
          end
        end
        ST_DISCARD: begin
          if (word_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  dc_fifo_rd_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk_i      (rd_clk),
    .rst_ni     (rd_rst_n),
    .push_i     (push),
    .push_data_i({push_last, fifo_rd_data[DATA_WIDTH-1:0]}),
    .m_tready_i (m_axis_tready),
    .m_tdata_o  (m_axis_tdata),
    .m_tlast_o  (m_axis_tlast),
    .m_tvalid_o (m_axis_tvalid),
    .pop_o      (pop),
    .count_o    (buf_count)
  );

  assign frame_done  = pop && m_axis_tlast;
  assign out_cnt_d   = frame_done ? '0 : (pop ? out_cnt_q + LEN_WIDTH'(1) : out_cnt_q);
  assign frame_len_d = frame_done ? out_cnt_q + LEN_WIDTH'(1) : frame_len_q;

  // A new error in the same cycle as a clear takes precedence.
  assign err_ovs_d   = ovs_set || (err_ovs_q && !err_clr);
  assign err_unexp_d = (fifo_rd_valid && (inflight_q == 2'd0)) || (err_unexp_q && !err_clr);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q     <= ST_IDLE;
      inflight_q  <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      frame_len_q <= '0;
      err_ovs_q   <= 1'b0;
      err_unexp_q <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      frame_len_q <= frame_len_d;
      err_ovs_q   <= err_ovs_d;
      err_unexp_q <= err_unexp_d;
      en_q        <= 1'b1;
    end
  end

  assign frame_len       = frame_len_d;
  assign frame_len_valid = frame_done;
  assign err_oversize    = err_ovs_q;
  assign err_unexpected  = err_unexp_q;

endmodule

// File: tb/tb_dc_fifo_stream_reader.sv
// Scoreboard bench for dc_fifo_stream_reader: frame-level reference model feeds
// expected beats and lengths; a negedge monitor compares every handshake.
module tb_dc_fifo_stream_reader;

  localparam int DW   = 32;
  localparam int MAXB = 8;
  localparam int LW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rd_rst_n;
  logic          fifo_rd_en;
  logic [DW:0]   fifo_rd_data;
  logic          fifo_rd_empty;
  logic          fifo_rd_valid;
  logic          fifo_rd_rst_busy;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [LW-1:0] frame_len;
  logic          frame_len_valid;
  logic          err_oversize;
  logic          err_unexpected;
  logic          err_clr;

  dc_fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .MAX_BEATS (MAXB)
  ) dut (
    .rd_clk          (clk),
    .rd_rst_n        (rd_rst_n),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_rd_data    (fifo_rd_data),
    .fifo_rd_empty   (fifo_rd_empty),
    .fifo_rd_valid   (fifo_rd_valid),
    .fifo_rd_rst_busy(fifo_rd_rst_busy),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .frame_len       (frame_len),
    .frame_len_valid (frame_len_valid),
    .err_oversize    (err_oversize),
    .err_unexpected  (err_unexpected),
    .err_clr         (err_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [DW:0]   src_q[$];
  logic [DW:0]   exp_q[$];
  logic [LW-1:0] exp_len_q[$];
  int            checks = 0;
  int            errors = 0;
  int            ready_mode = 0;
  logic          stall_en = 1'b0;
  logic          inj_unexp = 1'b0;
  logic          exp_ovs = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // FIFO read port model: one-cycle read latency, optional random empty stalls.
  initial begin
    logic take;
    fifo_rd_valid = 1'b0;
    fifo_rd_data  = '0;
    fifo_rd_empty = 1'b1;
    forever begin
      @(negedge clk);
      take = fifo_rd_en;
      @(posedge clk);
      #1;
      if (take && src_q.size() > 0) begin
        fifo_rd_data  = src_q.pop_front();
        fifo_rd_valid = 1'b1;
      end else if (inj_unexp) begin
        fifo_rd_data  = {1'b0, 32'hDEAD_BEEF};
        fifo_rd_valid = 1'b1;
        inj_unexp     = 1'b0;
      end else begin
        fifo_rd_valid = 1'b0;
      end
      fifo_rd_empty = (src_q.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
    end
  end

  // Sink ready: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = (ready_mode == 0) ? 1'b1 :
                      (ready_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Reference model: whole frames, truncated to MAXB beats with last forced on the cut.
  task automatic send_frame(input int len);
    logic [DW-1:0] d;
    logic          l;
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      l = (i == len - 1);
      src_q.push_back({l, d});
      if (i < MAXB) exp_q.push_back({l || (i == MAXB - 1), d});
    end
    exp_len_q.push_back(LW'((len > MAXB) ? MAXB : len));
    if (len > MAXB) exp_ovs = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0 || exp_len_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s drain_timeout actual=%0d beats_left required=0", name, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #2 err_clr = 1'b1;
    @(posedge clk); #2 err_clr = 1'b0;
  endtask

  // Monitor: scoreboard pops on each handshake plus AXI-S hold checks.
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_word  = '0;
  always @(negedge clk) begin
    if (!rd_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("axis_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_word});
      check("len_strobe", frame_len_valid, m_axis_tvalid && m_axis_tready && m_axis_tlast);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected actual=%0h required=none", {m_axis_tlast, m_axis_tdata});
        end else begin
          check("beat", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
        end
      end
      if (frame_len_valid) begin
        if (exp_len_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_len_unexpected actual=%0d required=none", frame_len);
        end else begin
          check("frame_len", frame_len, exp_len_q.pop_front());
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    int n;
    rd_rst_n = 1'b0;
    fifo_rd_rst_busy = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {fifo_rd_en, m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_len,
                            frame_len_valid, err_oversize, err_unexpected}, 64'd0);
    @(posedge clk); #2 rd_rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 3-word frame: request in N..N+2, first beat at N+2
    #2 send_frame(3);
    n = 0;
    do begin @(negedge clk); n++; end while (!fifo_rd_en && n < 20);
    check("t3_rd_en_n", fifo_rd_en, 1'b1);
    @(negedge clk);
    check("t3_rd_en_n1", fifo_rd_en, 1'b1);
    check("t3_tvalid_n1", m_axis_tvalid, 1'b0);
    @(negedge clk);
    check("t3_rd_en_n2", fifo_rd_en, 1'b1);
    check("t3_tvalid_n2", m_axis_tvalid, 1'b1);
    wait_drain("t3");

    // 8-word frame (exactly max) with a backpressure window
    @(posedge clk); #2 send_frame(8);
    repeat (3) @(posedge clk);
    #2 ready_mode = 2;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("bp_rd_en_stop", fifo_rd_en, 1'b0);
    check("bp_tvalid_held", m_axis_tvalid, 1'b1);
    #2 ready_mode = 0;
    wait_drain("bp");
    check("max_len_no_ovs", err_oversize, 1'b0);

    // oversize frames followed by intact frames, including single-beat frames
    @(posedge clk); #2 send_frame(10); send_frame(2);
    wait_drain("ovs10");
    check("ovs10_flag", err_oversize, 1'b1);
    pulse_clr();
    @(negedge clk);
    check("ovs_cleared", err_oversize, 1'b0);
    @(posedge clk); #2 send_frame(9); send_frame(1); send_frame(1);
    wait_drain("ovs9");
    check("ovs9_flag", err_oversize, 1'b1);
    pulse_clr();

    // unexpected rd_valid, set-wins-over-clear, then clear
    repeat (4) @(posedge clk);
    #2 inj_unexp = 1'b1;
    @(posedge clk); #2 err_clr = 1'b1;
    @(posedge clk); #2 err_clr = 1'b0;
    @(negedge clk);
    check("unexp_set_wins", err_unexpected, 1'b1);
    check("unexp_no_beat", m_axis_tvalid, 1'b0);
    pulse_clr();
    @(negedge clk);
    check("unexp_cleared", err_unexpected, 1'b0);
    check("ovs_still_clear", err_oversize, 1'b0);

    // FIFO read side busy gates the request only
    @(posedge clk); #2 fifo_rd_rst_busy = 1'b1; send_frame(3);
    repeat (6) begin
      @(negedge clk);
      check("busy_rd_en", fifo_rd_en, 1'b0);
    end
    @(posedge clk); #2 fifo_rd_rst_busy = 1'b0;
    @(negedge clk);
    check("busy_release", fifo_rd_en, 1'b1);
    wait_drain("busy");

    // randomized frames with random backpressure and FIFO stalls
    exp_ovs = 1'b0;
    @(posedge clk); #2 ready_mode = 1; stall_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      send_frame($urandom_range(1, MAXB + 3));
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #2;
    end
    wait_drain("random");
    check("random_ovs", err_oversize, exp_ovs);
    check("random_unexp", err_unexpected, 1'b0);
    pulse_clr();
    @(posedge clk); #2 ready_mode = 0; stall_en = 1'b0;

    // asynchronous reset mid-frame with tvalid high
    @(posedge clk); #2 ready_mode = 2; exp_ovs = 1'b0; send_frame(MAXB + 2);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_axis_tvalid && n < 20);
    check("rst_pre_tvalid", m_axis_tvalid, 1'b1);
    @(posedge clk); #2 rd_rst_n = 1'b0;
    src_q.delete(); exp_q.delete(); exp_len_q.delete();
    #1;
    check("rst_mid_outputs", {fifo_rd_en, m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_len,
                              frame_len_valid, err_oversize, err_unexpected}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rd_rst_n = 1'b1; ready_mode = 0;
    repeat (2) @(posedge clk);
    #2 send_frame(2);
    wait_drain("post_reset");
    check("post_reset_ovs", err_oversize, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
